// File: rtl/masked_sbox_input_map.sv
// ---------------------------------------------------------------------------
// masked_sbox_input_map
//
// Input-side linear stage of a 2-share masked Canright AES S-box. Each
// Boolean share of a polynomial-basis byte is mapped into the tower-field
// GF((2^4)^2) basis that feeds the masked inverter. In inverse (InvSubBytes)
// mode the affine constant 0x63 is first removed from share 0, and the
// inverse-cipher basis change is used instead of the forward one.
//
// Two-stage valid/ready pipeline:
//   stage 1 : basis change of both shares (registered)
//   stage 2 : optional share refresh with fresh randomness (registered)
//
// Parameters
//   REFRESH   1: XOR rnd into both shares on the stage1->stage2 transfer
//             0: stage 2 is a plain register
//
// Ports
//   clk        in   1  clock
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  input byte present
//   in_ready   out  1  stage 1 can accept this cycle
//   inv_mode   in   1  0 = forward map, 1 = inverse map (sampled with data)
//   sin0       in   8  share 0, polynomial basis
//   sin1       in   8  share 1, polynomial basis
//   rnd        in   8  fresh randomness, sampled on stage1->stage2 transfer
//   out_valid  out  1  stage 2 holds valid data
//   out_ready  in   1  downstream accepts
//   out_inv    out  1  inv_mode carried with the data
//   sout0      out  8  share 0, tower basis
//   sout1      out  8  share 1, tower basis
// ---------------------------------------------------------------------------
module masked_sbox_input_map #(
    parameter bit REFRESH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       inv_mode,
    input  logic [7:0] sin0,
    input  logic [7:0] sin1,
    input  logic [7:0] rnd,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_inv,
    output logic [7:0] sout0,
    output logic [7:0] sout1
);

    // Basis tables packed so that input bit i selects byte lane i:
    // lane 0 holds the last table entry, lane 7 the first.
    localparam logic [63:0] A2X_TBL  = 64'h98F3_F248_0981_A9FF;
    localparam logic [63:0] S2X_TBL  = 64'h8C79_05EB_1204_5153;
    localparam logic [7:0]  AFFINE_C = 8'h63;

    // GF(2)-linear basis change: XOR of the table rows selected by x.
    function automatic logic [7:0] newbasis(input logic [7:0] x, input logic [63:0] tbl);
        logic [7:0] y;
        y = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) begin
                y = y ^ tbl[8*i +: 8];
            end else begin
                y = y;
            end
        end
        return y;
    endfunction

    // Stage registers
    logic       r_s1_valid;
    logic       r_s1_inv;
    logic [7:0] r_s1_d0;
    logic [7:0] r_s1_d1;
    logic       r_s2_valid;
    logic       r_s2_inv;
    logic [7:0] r_s2_d0;
    logic [7:0] r_s2_d1;

    // Handshake and datapath wires
    logic       w_s2_adv;
    logic       w_s1_adv;
    logic       w_in_ready;
    logic       w_accept;
    logic [7:0] w_map0;
    logic [7:0] w_map1;
    logic [7:0] w_refresh;

    assign w_s2_adv   = (!r_s2_valid) || out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_adv;
    assign w_in_ready = (!r_s1_valid) || w_s2_adv;
    assign w_accept   = in_valid && w_in_ready;
    assign w_refresh  = REFRESH ? rnd : 8'h00;

    // Per-share basis change; the affine constant is removed from share 0
    // only so the two shares are never combined.
    always_comb begin
        w_map0 = 8'h00;
        w_map1 = 8'h00;
        if (inv_mode) begin
            w_map0 = newbasis(sin0 ^ AFFINE_C, S2X_TBL);
            w_map1 = newbasis(sin1, S2X_TBL);
        end else begin
            w_map0 = newbasis(sin0, A2X_TBL);
            w_map1 = newbasis(sin1, A2X_TBL);
        end
    end

    // Stage 1: capture mapped shares on accept; data holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_inv   <= 1'b0;
            r_s1_d0    <= 8'h00;
            r_s1_d1    <= 8'h00;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_inv   <= inv_mode;
                r_s1_d0    <= w_map0;
                r_s1_d1    <= w_map1;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end else begin
                r_s1_valid <= r_s1_valid;
            end
        end
    end

    // Stage 2: refresh both shares with the same mask on transfer from stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_inv   <= 1'b0;
            r_s2_d0    <= 8'h00;
            r_s2_d1    <= 8'h00;
        end else begin
            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_s2_inv   <= r_s1_inv;
                r_s2_d0    <= r_s1_d0 ^ w_refresh;
                r_s2_d1    <= r_s1_d1 ^ w_refresh;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end else begin
                r_s2_valid <= r_s2_valid;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign out_inv   = r_s2_inv;
    assign sout0     = r_s2_d0;
    assign sout1     = r_s2_d1;

endmodule

// File: tb/tb_masked_sbox_input_map.sv
// ---------------------------------------------------------------------------
// tb_masked_sbox_input_map
//
// Directed self-checking bench. Two instances share all inputs: u_ref with
// share refresh enabled and u_nr with refresh disabled. Inputs are driven
// and outputs observed on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_masked_sbox_input_map;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       inv_mode;
    logic [7:0] sin0;
    logic [7:0] sin1;
    logic [7:0] rnd;
    logic       out_ready;

    logic       in_ready;
    logic       out_valid;
    logic       out_inv;
    logic [7:0] sout0;
    logic [7:0] sout1;

    logic       nr_in_ready;
    logic       nr_out_valid;
    logic       nr_out_inv;
    logic [7:0] nr_sout0;
    logic [7:0] nr_sout1;

    int n_total;
    int n_bad;

    logic [7:0] A2X [8] = '{8'h98, 8'hF3, 8'hF2, 8'h48, 8'h09, 8'h81, 8'hA9, 8'hFF};
    logic [7:0] S2X [8] = '{8'h8C, 8'h79, 8'h05, 8'hEB, 8'h12, 8'h04, 8'h51, 8'h53};

    logic [7:0] t5_s0  [260];
    logic [7:0] t5_s1  [260];
    logic       t5_inv [260];
    logic [7:0] t5_rnd [260];

    masked_sbox_input_map #(.REFRESH(1'b1)) u_ref (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inv_mode(inv_mode), .sin0(sin0), .sin1(sin1), .rnd(rnd),
        .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv),
        .sout0(sout0), .sout1(sout1)
    );

    masked_sbox_input_map #(.REFRESH(1'b0)) u_nr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nr_in_ready),
        .inv_mode(inv_mode), .sin0(sin0), .sin1(sin1), .rnd(rnd),
        .out_valid(nr_out_valid), .out_ready(out_ready), .out_inv(nr_out_inv),
        .sout0(nr_sout0), .sout1(nr_sout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference basis change: x[i] selects table entry 7-i.
    function automatic logic [7:0] nb(input logic [7:0] x, input logic inv);
        logic [7:0] y;
        y = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) y = y ^ (inv ? S2X[7-i] : A2X[7-i]);
        end
        return y;
    endfunction

    function automatic logic [7:0] map_s0(input logic [7:0] s, input logic inv);
        return inv ? nb(s ^ 8'h63, 1'b1) : nb(s, 1'b0);
    endfunction

    function automatic logic [7:0] map_s1(input logic [7:0] s, input logic inv);
        return nb(s, inv);
    endfunction

    // One isolated transfer with out_ready held high; r is the refresh mask.
    task automatic run_single(input string tag, input logic inv, input logic [7:0] s0,
                              input logic [7:0] s1, input logic [7:0] r,
                              input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] n0, input logic [7:0] n1);
        @(negedge clk);
        in_valid = 1'b1; inv_mode = inv; sin0 = s0; sin1 = s1; out_ready = 1'b1; rnd = 8'h00;
        @(negedge clk);
        check_val({tag, "_lat"}, out_valid, 1'b0);
        in_valid = 1'b0; rnd = r;
        @(negedge clk);
        check_val({tag, "_valid"}, out_valid, 1'b1);
        check_val({tag, "_sout0"}, sout0, e0);
        check_val({tag, "_sout1"}, sout1, e1);
        check_val({tag, "_inv"}, out_inv, inv);
        check_val({tag, "_nr_sout0"}, nr_sout0, n0);
        check_val({tag, "_nr_sout1"}, nr_sout1, n1);
        rnd = 8'h00;
    endtask

    initial begin
        logic [7:0] q_s0  [4];
        logic [7:0] q_s1  [4];
        logic       q_inv [4];
        int idx;
        int got;
        int k;

        n_total = 0; n_bad = 0;
        rst = 1'b1; in_valid = 1'b0; inv_mode = 1'b0;
        sin0 = 8'h00; sin1 = 8'h00; rnd = 8'h00; out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_sout0", sout0, 8'h00);
        check_val("rst_sout1", sout1, 8'h00);
        check_val("rst_out_inv", out_inv, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_idle_valid", out_valid, 1'b0);

        // T1: 53 -> ED (REFRESH=0 exact), refresh instance masked with 5A
        run_single("t1", 1'b0, 8'h53, 8'h00, 8'h5A, 8'hB7, 8'h5A, 8'hED, 8'h00);
        // T2: split 50/03, mask 3C
        run_single("t2", 1'b0, 8'h50, 8'h03, 8'h3C, 8'h87, 8'h6A, 8'hBB, 8'h56);
        check_val("t2_recomb", sout0 ^ sout1, 8'hED);
        // T3: inverse, 62^63=01 -> 53, mask A5
        run_single("t3", 1'b1, 8'h62, 8'h00, 8'hA5, 8'hF6, 8'hA5, 8'h53, 8'h00);
        // Constant applies to share 0 only: both shares map to 7E
        run_single("t3b", 1'b1, 8'h00, 8'h63, 8'h00, 8'h7E, 8'h7E, 8'h7E, 8'h7E);

        // T4: backpressure for 5 cycles with a stream of 4 inputs, rnd = 0
        q_s0  = '{8'h11, 8'h22, 8'h33, 8'h44};
        q_s1  = '{8'hA0, 8'h0B, 8'h5C, 8'hD7};
        q_inv = '{1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        out_ready = 1'b0; rnd = 8'h00; in_valid = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check_val("t4_hold_valid", out_valid, 1'b1);
                check_val("t4_hold_sout0", sout0, map_s0(q_s0[0], q_inv[0]));
                check_val("t4_hold_sout1", sout1, map_s1(q_s1[0], q_inv[0]));
                check_val("t4_hold_inv", out_inv, q_inv[0]);
            end
            in_valid = (idx < 4); sin0 = q_s0[idx % 4]; sin1 = q_s1[idx % 4]; inv_mode = q_inv[idx % 4];
            #1;
            if (in_valid && in_ready) idx++;
        end
        check_val("t4_accepted", idx, 2);
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (out_valid) begin
                check_val("t4_order_sout0", sout0, map_s0(q_s0[got], q_inv[got]));
                check_val("t4_order_sout1", sout1, map_s1(q_s1[got], q_inv[got]));
                check_val("t4_order_inv", out_inv, q_inv[got]);
                got++;
            end
            if (idx < 4) begin
                in_valid = 1'b1; sin0 = q_s0[idx]; sin1 = q_s1[idx]; inv_mode = q_inv[idx];
                #1;
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        check_val("t4_delivered", got, 4);
        @(negedge clk);
        check_val("t4_no_dup", out_valid, 1'b0);

        // T5: 256 back-to-back bytes, alternating mode, random shares and masks
        for (int cyc = 0; cyc < 259; cyc++) begin
            @(negedge clk);
            if (cyc >= 2 && cyc < 258) begin
                k = cyc - 2;
                check_val("t5_valid", out_valid, 1'b1);
                check_val("t5_recomb", sout0 ^ sout1, map_s0(t5_s0[k] ^ t5_s1[k], t5_inv[k]));
                check_val("t5_sout1", sout1, map_s1(t5_s1[k], t5_inv[k]) ^ t5_rnd[k+1]);
                check_val("t5_inv", out_inv, t5_inv[k]);
                check_val("t5_nr_sout0", nr_sout0, map_s0(t5_s0[k], t5_inv[k]));
                check_val("t5_nr_sout1", nr_sout1, map_s1(t5_s1[k], t5_inv[k]));
            end
            if (cyc == 258) check_val("t5_drained", out_valid, 1'b0);
            if (cyc < 256) begin
                t5_s0[cyc] = 8'($urandom); t5_s1[cyc] = 8'($urandom); t5_inv[cyc] = cyc[0];
                in_valid = 1'b1; sin0 = t5_s0[cyc]; sin1 = t5_s1[cyc]; inv_mode = t5_inv[cyc];
            end else begin
                in_valid = 1'b0;
            end
            t5_rnd[cyc] = 8'($urandom);
            rnd = t5_rnd[cyc];
            #1;
            if (cyc < 256) check_val("t5_in_ready", in_ready, 1'b1);
        end

        // T6: reset while both stages are full
        @(negedge clk);
        out_ready = 1'b0; rnd = 8'hFF;
        in_valid = 1'b1; inv_mode = 1'b1; sin0 = 8'hC3; sin1 = 8'h3C;
        @(negedge clk);
        in_valid = 1'b1; inv_mode = 1'b1; sin0 = 8'h5A; sin1 = 8'hA5;
        #1;
        check_val("t6_fill_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_val("t6_full_valid", out_valid, 1'b1);
        check_val("t6_full_inv", out_inv, 1'b1);
        check_val("t6_full_ready", in_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_valid", out_valid, 1'b0);
        check_val("t6_rst_ready", in_ready, 1'b1);
        check_val("t6_rst_sout0", sout0, 8'h00);
        check_val("t6_rst_sout1", sout1, 8'h00);
        check_val("t6_rst_inv", out_inv, 1'b0);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check_val("t6_post_ready", in_ready, 1'b1);
        check_val("t6_dropped", out_valid, 1'b0);
        @(negedge clk);
        check_val("t6_dropped2", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
